// File: rtl/link_tx_arbiter.sv
// ============================================================================
// link_tx_arbiter : round-robin arbiter sharing one FPGA-to-FPGA sender link
// Optional feature macro: ARB_TIMEOUT_EN (BUSY timeout counter + ABORT state)
// Revision: 1.0
// ============================================================================
`default_nettype none

module link_tx_arbiter #(
    parameter int NUM_CLIENTS    = 4,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_CLIENTS-1:0]    cli_req,
    input  logic [32*NUM_CLIENTS-1:0] cli_data,
    output logic [NUM_CLIENTS-1:0]    cli_grant,
    output logic [NUM_CLIENTS-1:0]    cli_done,
    output logic [NUM_CLIENTS-1:0]    cli_err,
    output logic                      sender_start,
    output logic [31:0]               sender_data,
    input  logic                      sender_done,
    output logic                      sender_rst
);

    localparam int IDX_W = $clog2(NUM_CLIENTS);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_BUSY  = 2'd2,
        S_ABORT = 2'd3
    } state_t;

    state_t                   state_q, state_d;
    logic [IDX_W-1:0]         rr_q, rr_d;
    logic [IDX_W-1:0]         gidx_q, gidx_d;
    logic [NUM_CLIENTS-1:0]   grant_q, grant_d;
    logic [NUM_CLIENTS-1:0]   done_q, done_d;
    logic                     start_q, start_d;

    logic                     arb_found;
    logic [IDX_W-1:0]         arb_idx;
    logic [IDX_W-1:0]         cand;

`ifdef ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic [NUM_CLIENTS-1:0]   err_q, err_d;
    logic                     srst_q, srst_d;
`endif

    // Scan from farthest to nearest so the first requester after rr_q wins.
    always_comb begin
        arb_found = 1'b0;
        arb_idx   = '0;
        cand      = '0;
        for (int i = NUM_CLIENTS; i >= 1; i--) begin
            cand = IDX_W'((int'(rr_q) + i) % NUM_CLIENTS);
            if (cli_req[cand]) begin
                arb_found = 1'b1;
                arb_idx   = cand;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        rr_d    = rr_q;
        gidx_d  = gidx_q;
        grant_d = grant_q;
        done_d  = '0;
        start_d = 1'b0;
`ifdef ARB_TIMEOUT_EN
        cnt_d   = cnt_q;
        err_d   = '0;
        srst_d  = 1'b0;
`endif
        case (state_q)
            S_IDLE: begin
                if (arb_found) begin
                    gidx_d  = arb_idx;
                    grant_d = NUM_CLIENTS'(1) << arb_idx;
                    start_d = 1'b1;
                    state_d = S_START;
                end
            end
            S_START: begin
`ifdef ARB_TIMEOUT_EN
                cnt_d   = '0;
`endif
                state_d = S_BUSY;
            end
            S_BUSY: begin
                // Done takes priority over a coincident timeout.
                if (sender_done) begin
                    done_d  = grant_q;
                    grant_d = '0;
                    rr_d    = gidx_q;
                    state_d = S_IDLE;
                end
`ifdef ARB_TIMEOUT_EN
                else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    err_d   = grant_q;
                    srst_d  = 1'b1;
                    grant_d = '0;
                    rr_d    = gidx_q;
                    state_d = S_ABORT;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
`endif
            end
`ifdef ARB_TIMEOUT_EN
            S_ABORT: begin
                state_d = S_IDLE;
            end
`endif
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            rr_q    <= IDX_W'(NUM_CLIENTS - 1);
            gidx_q  <= '0;
            grant_q <= '0;
            done_q  <= '0;
            start_q <= 1'b0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            gidx_q  <= gidx_d;
            grant_q <= grant_d;
            done_q  <= done_d;
            start_q <= start_d;
        end
    end

`ifdef ARB_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q  <= '0;
            err_q  <= '0;
            srst_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            err_q  <= err_d;
            srst_q <= srst_d;
        end
    end

    assign cli_err    = err_q;
    assign sender_rst = srst_q;
`else
    assign cli_err    = '0;
    assign sender_rst = 1'b0;
`endif

    // Grant is one-hot, so an OR-of-selected-slices mux is sufficient.
    always_comb begin
        sender_data = '0;
        for (int i = 0; i < NUM_CLIENTS; i++) begin
            if (grant_q[i]) begin
                sender_data = cli_data[32*i +: 32];
            end
        end
    end

    assign cli_grant    = grant_q;
    assign cli_done     = done_q;
    assign sender_start = start_q;

endmodule

`default_nettype wire

// File: tb/tb_link_tx_arbiter.sv
// ============================================================================
// tb_link_tx_arbiter : directed self-checking bench for link_tx_arbiter
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_link_tx_arbiter;

    localparam int N = 4;
    localparam int T = 16;

    logic              clk;
    logic              rst;
    logic [N-1:0]      cli_req;
    logic [32*N-1:0]   cli_data;
    logic [N-1:0]      cli_grant;
    logic [N-1:0]      cli_done;
    logic [N-1:0]      cli_err;
    logic              sender_start;
    logic [31:0]       sender_data;
    logic              sender_done;
    logic              sender_rst;

    logic [31:0]       words [N];
    int                n_checks = 0;
    int                n_pass   = 0;

    link_tx_arbiter #(
        .NUM_CLIENTS    (N),
        .TIMEOUT_CYCLES (T)
    ) u_dut (
        .clk          (clk),
        .rst          (rst),
        .cli_req      (cli_req),
        .cli_data     (cli_data),
        .cli_grant    (cli_grant),
        .cli_done     (cli_done),
        .cli_err      (cli_err),
        .sender_start (sender_start),
        .sender_data  (sender_data),
        .sender_done  (sender_done),
        .sender_rst   (sender_rst)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_grant"}, 32'(cli_grant), 32'h0);
        check({tag, "_start"}, 32'(sender_start), 32'h0);
        check({tag, "_done"},  32'(cli_done), 32'h0);
        check({tag, "_err"},   32'(cli_err), 32'h0);
        check({tag, "_srst"},  32'(sender_rst), 32'h0);
        check({tag, "_data"},  sender_data, 32'h0);
    endtask

    // Waits for a grant and checks the START-cycle view.
    task automatic wait_grant(input int idx, input int exp_lat, input string tag);
        int waited;
        logic [N-1:0] g;
        g = N'(1) << idx;
        waited = 0;
        do begin
            tick();
            waited++;
        end while (cli_grant == '0 && waited < exp_lat + 5);
        check({tag, "_lat"},   32'(waited), 32'(exp_lat));
        check({tag, "_grant"}, 32'(cli_grant), 32'(g));
        check({tag, "_start"}, 32'(sender_start), 32'h1);
        check({tag, "_data"},  sender_data, words[idx]);
        check({tag, "_dclr"},  32'(cli_done), 32'h0);
    endtask

    // Full transfer: sender_done raised 1+lat cycles after the START cycle.
    task automatic serve(input int idx, input int lat, input int exp_lat, input string tag);
        logic [N-1:0] g;
        g = N'(1) << idx;
        wait_grant(idx, exp_lat, tag);
        tick();
        check({tag, "_stoff"}, 32'(sender_start), 32'h0);
        check({tag, "_hold"},  32'(cli_grant), 32'(g));
        repeat (lat) tick();
        sender_done = 1'b1;
        tick();
        sender_done = 1'b0;
        check({tag, "_cdone"}, 32'(cli_done), 32'(g));
        check({tag, "_gdrop"}, 32'(cli_grant), 32'h0);
        check({tag, "_noerr"}, 32'(cli_err), 32'h0);
        check({tag, "_nosrst"}, 32'(sender_rst), 32'h0);
    endtask

    initial begin
        words[0] = 32'hA0A0_1000;
        words[1] = 32'hB1B1_2001;
        words[2] = 32'hC2C2_3002;
        words[3] = 32'hD3D3_4003;
        for (int i = 0; i < N; i++) cli_data[32*i +: 32] = words[i];
        rst         = 1'b1;
        cli_req     = '0;
        sender_done = 1'b0;

        // Reset state and first transfer (done 12 cycles after START)
        repeat (3) tick();
        check_idle_outputs("reset");
        rst     = 1'b0;
        cli_req = 4'b0001;
        serve(0, 11, 1, "first");
        cli_req     = '0;
        sender_done = 1'b1;
        tick();
        sender_done = 1'b0;
        check("stray_done", 32'(cli_done), 32'h0);
        check("stray_grant", 32'(cli_grant), 32'h0);

        // Fairness from reset: 0,1,2,3,0
        rst     = 1'b1;
        cli_req = 4'b1111;
        tick();
        rst = 1'b0;
        serve(0, 2, 1, "rr0");
        serve(1, 3, 1, "rr1");
        serve(2, 4, 1, "rr2");
        serve(3, 5, 1, "rr3");
        serve(0, 6, 1, "rr4");

        // Client 2 loops, client 1 still gets every other slot
        cli_req = 4'b0110;
        serve(1, 3, 1, "lk0");
        serve(2, 3, 1, "lk1");
        serve(1, 3, 1, "lk2");
        serve(2, 3, 1, "lk3");

        // Reset during BUSY: silent abandon, client 0 first afterwards
        cli_req = 4'b1001;
        wait_grant(3, 1, "mid");
        tick();
        tick();
        rst = 1'b1;
        tick();
        check_idle_outputs("midrst");
        rst = 1'b0;
        serve(0, 4, 1, "post");

`ifdef ARB_TIMEOUT_EN
        // Timeout: abort 17 cycles after START, then next requester
        cli_req = 4'b0110;
        wait_grant(1, 1, "to");
        repeat (T) tick();
        check("to_early_srst", 32'(sender_rst), 32'h0);
        check("to_early_err", 32'(cli_err), 32'h0);
        tick();
        check("to_srst", 32'(sender_rst), 32'h1);
        check("to_err", 32'(cli_err), 32'h2);
        check("to_gdrop", 32'(cli_grant), 32'h0);
        check("to_done", 32'(cli_done), 32'h0);
        tick();
        check("to_srst_pulse", 32'(sender_rst), 32'h0);
        check("to_err_pulse", 32'(cli_err), 32'h0);
        serve(2, 3, 1, "to_next");
        // Done lands exactly at counter == T-1: done wins
        serve(1, T - 1, 1, "sim");
`else
        // Without timeout, a long sender latency still completes
        cli_req = 4'b0010;
        serve(1, 40, 1, "long");
`endif

        cli_req = '0;
        tick();
        tick();
        check_idle_outputs("final");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/link_tx_arbiter.md
# link_tx_arbiter

Round-robin arbiter that shares one FPGA-to-FPGA sender link among NUM_CLIENTS local processes. It grants one requester at a time and pulses the sender's start. It steers the granted client's 32-bit word onto the sender's data input and waits for the sender's done. It reports completion, or a timeout abort, back to the granted client. It sits between the local process blocks and the sender on FPGA 1. At top level the sender's reset is driven by rst OR sender_rst.

## Interface
- NUM_CLIENTS, 4: number of requesters, legal range 2..8.
- TIMEOUT_CYCLES, 1024: maximum BUSY cycles before abort, minimum 2.
- clk  in  1  clock.
- rst  in  1  reset: synchronous, active-high. Clock is clk.
- cli_req  in  NUM_CLIENTS  level request per client; held until cli_done or cli_err.
- cli_data  in  32*NUM_CLIENTS  client i word in bits [32*i+31:32*i]; streamed by the client while granted.
- cli_grant  out  NUM_CLIENTS  one-hot registered grant.
- cli_done  out  NUM_CLIENTS  one-cycle success pulse to the granted client.
- cli_err  out  NUM_CLIENTS  one-cycle abort pulse to the granted client.
- sender_start  out  1  one-cycle start pulse to the sender.
- sender_data  out  32  combinational mux of the granted client's slice; 0 when no grant.
- sender_done  in  1  done pulse from the sender.
- sender_rst  out  1  one-cycle abort reset to the sender.

## Operation
- Reset values:
  - all registered outputs 0; sender_data 0.
  - state IDLE; rr_ptr = NUM_CLIENTS-1, so client 0 wins first; timeout counter 0.
  - rst mid-transfer abandons the transfer silently: no cli_done or cli_err.
- States: IDLE, START, BUSY, ABORT.
- IDLE:
  - If any cli_req is set, choose the first requester scanning rr_ptr+1, rr_ptr+2, ... with modulo NUM_CLIENTS wrap.
  - Register grant_idx, cli_grant one-hot and sender_start=1, then go to START.
  - If no request, stay in IDLE.
- START: lasts exactly one cycle. sender_start is high. Clear the counter and go to BUSY.
- BUSY:
  - sender_start is 0 and the counter increments each cycle.
  - When sender_done is sampled high:
    - next cycle cli_done[grant_idx]=1 and cli_grant=0;
    - rr_ptr is set to grant_idx;
    - state goes to IDLE.
  - When counter == TIMEOUT_CYCLES-1 and sender_done is low, go to ABORT.
- ABORT: lasts one cycle.
  - sender_rst=1, cli_err[grant_idx]=1, cli_grant=0.
  - rr_ptr is set to grant_idx; then go to IDLE.
- Boundary rules:
  - sender_done and timeout in the same cycle: done wins, with no abort.
  - Client drops cli_req while granted: ignored, the transfer runs to completion or abort.
  - sender_done outside BUSY: ignored.
  - Counter width is $clog2(TIMEOUT_CYCLES+1) and it never wraps.
  - cli_done and cli_err are mutually exclusive and apply to the granted index only.

## Timing
- Request visible at edge n:
  - cli_grant and sender_start are high after edge n+1.
  - sender_start drops after edge n+2.
- sender_done high at edge k: cli_done is high for the cycle after edge k+1, and grant drops at the same edge.
- Earliest next grant is after edge k+2, because IDLE re-arbitrates from there.
- Back-to-back overhead is 2 cycles per transfer beyond the sender latency.
- Abort latency: cli_err and sender_rst are asserted TIMEOUT_CYCLES+1 cycles after the START cycle.

## Configuration
- ARB_TIMEOUT_EN defined:
  - timeout counter and ABORT state are present, as described above.
- ARB_TIMEOUT_EN undefined:
  - no counter; BUSY waits indefinitely for sender_done;
  - sender_rst and cli_err are tied to 0; ABORT is not synthesized.

## Test plan
- Reset check: after rst, with cli_req=4'b0001 and a sender done 12 cycles after start, expect:
  - grant 4'b0001 after 1 edge, with sender_start for exactly one cycle;
  - sender_data equals cli_data[31:0];
  - cli_done[0] pulses and returns to IDLE.
- Fairness: hold cli_req=4'b1111 and complete each transfer; expect grant order 0,1,2,3,0.
- Lockout check: with client 2 looping on request, client 1 is never locked out.
- Timeout (ARB_TIMEOUT_EN, TIMEOUT_CYCLES=16): with sender_done never asserted, expect:
  - sender_rst and cli_err[granted] for one cycle, 17 cycles after START;
  - the next requester is granted afterwards.
- Simultaneous done and timeout: sender_done lands exactly at counter=15; expect cli_done, with no cli_err and no sender_rst.
- Reset mid-BUSY: assert rst; expect all outputs 0 the next cycle, no done/err pulse, and client 0 granted first afterwards.
